// File: rtl/wreg_loader.sv
// rtl/wreg_loader.sv - sequencer loading a WREG weight bank from weight memory
module wreg_loader #(
  parameter int WLOAD_DATA_WIDTH = 8,
  parameter int WLOAD_NUM_REGS   = 9,
  parameter int WLOAD_ADDR_WIDTH = 10,
  parameter int WLOAD_IDX_WIDTH  = 4
) (
  input  logic                        WLOAD_Clk,
  input  logic                        WLOAD_Reset,
  input  logic                        WLOAD_Start,
  input  logic [WLOAD_ADDR_WIDTH-1:0] WLOAD_Base_Addr,
  output logic                        WLOAD_Mem_Req,
  output logic [WLOAD_ADDR_WIDTH-1:0] WLOAD_Mem_Addr,
  input  logic                        WLOAD_Mem_Ack,
  input  logic [WLOAD_DATA_WIDTH-1:0] WLOAD_Mem_Data,
  output logic [WLOAD_NUM_REGS-1:0]   WLOAD_Set,
  output logic [WLOAD_DATA_WIDTH-1:0] WLOAD_Output_Data,
  output logic                        WLOAD_Busy,
  output logic                        WLOAD_Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WLOAD_IDX_WIDTH-1:0] LAST_IDX = WLOAD_IDX_WIDTH'(WLOAD_NUM_REGS - 1);
  localparam logic [WLOAD_NUM_REGS-1:0]  SET_ONE  = WLOAD_NUM_REGS'(1);

  state_t                      state, state_n;
  logic [WLOAD_IDX_WIDTH-1:0]  idx, idx_n, idx_inc;
  logic [WLOAD_ADDR_WIDTH-1:0] base, base_n;
  logic                        req_n;
  logic [WLOAD_ADDR_WIDTH-1:0] addr_n;
  logic [WLOAD_NUM_REGS-1:0]   set_n;
  logic [WLOAD_DATA_WIDTH-1:0] data_n;
  logic                        busy_n;
  logic                        done_n;

  assign idx_inc = idx + 1'b1;

  // State and registered outputs; async reset aborts any load in flight
  always_ff @(posedge WLOAD_Clk or negedge WLOAD_Reset) begin
    if (!WLOAD_Reset) begin
      state             <= S_IDLE;
      idx               <= '0;
      base              <= '0;
      WLOAD_Mem_Req     <= 1'b0;
      WLOAD_Mem_Addr    <= '0;
      WLOAD_Set         <= '0;
      WLOAD_Output_Data <= '0;
      WLOAD_Busy        <= 1'b0;
      WLOAD_Done        <= 1'b0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      base              <= base_n;
      WLOAD_Mem_Req     <= req_n;
      WLOAD_Mem_Addr    <= addr_n;
      WLOAD_Set         <= set_n;
      WLOAD_Output_Data <= data_n;
      WLOAD_Busy        <= busy_n;
      WLOAD_Done        <= done_n;
    end
  end

  // Next-state and next-output decode; Set and Done default low so they pulse
  always_comb begin
    state_n = state;
    idx_n   = idx;
    base_n  = base;
    req_n   = WLOAD_Mem_Req;
    addr_n  = WLOAD_Mem_Addr;
    set_n   = '0;
    data_n  = WLOAD_Output_Data;
    busy_n  = WLOAD_Busy;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (WLOAD_Start) begin
          base_n  = WLOAD_Base_Addr;
          idx_n   = '0;
          req_n   = 1'b1;
          addr_n  = WLOAD_Base_Addr;
          busy_n  = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (WLOAD_Mem_Ack) begin
          data_n  = WLOAD_Mem_Data;
          set_n   = SET_ONE << idx;
          req_n   = 1'b0;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx == LAST_IDX) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          idx_n   = idx_inc;
          req_n   = 1'b1;
          // Address wraps naturally at the memory address width
          addr_n  = base + WLOAD_ADDR_WIDTH'(idx_inc);
          state_n = S_REQ;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wreg_loader.sv
// tb/tb_wreg_loader.sv - directed self-checking bench for wreg_loader
module tb_wreg_loader;

  localparam int DW = 8;
  localparam int NR = 9;
  localparam int AW = 10;

  logic          tb_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [NR-1:0] set;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] wreg [NR] = '{default: '0};

  int checks = 0;
  int errors = 0;
  int max_delay = 0;
  bit inject_ack = 1'b0;

  always #5 tb_clk = ~tb_clk;

  wreg_loader dut (
    .WLOAD_Clk         (tb_clk),
    .WLOAD_Reset       (rst_n),
    .WLOAD_Start       (start),
    .WLOAD_Base_Addr   (base_addr),
    .WLOAD_Mem_Req     (mem_req),
    .WLOAD_Mem_Addr    (mem_addr),
    .WLOAD_Mem_Ack     (mem_ack),
    .WLOAD_Mem_Data    (mem_data),
    .WLOAD_Set         (set),
    .WLOAD_Output_Data (out_data),
    .WLOAD_Busy        (busy),
    .WLOAD_Done        (done)
  );

  // WREG bank: each register captures the shared bus on its Set strobe
  always @(posedge tb_clk) begin
    for (int i = 0; i < NR; i++)
      if (set[i]) wreg[i] <= out_data;
  end

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Weight memory: acks after a random 0..max_delay wait, data = addr ^ A5
  initial begin
    bit pend;
    int cnt;
    pend     = 1'b0;
    cnt      = 0;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge tb_clk);
      if (inject_ack) begin
        mem_ack    = 1'b1;
        mem_data   = 8'h5A;
        inject_ack = 1'b0;
      end else if (!rst_n) begin
        mem_ack = 1'b0;
        pend    = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        pend    = 1'b0;
      end else if (mem_req) begin
        if (!pend) begin
          pend = 1'b1;
          cnt  = $urandom_range(0, max_delay);
        end else if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = exp_word(mem_addr);
        end else begin
          cnt--;
        end
      end
    end
  end

  // Protocol monitor sampled 1 time unit after each rising edge
  initial begin
    logic          prev_req;
    logic [AW-1:0] prev_addr;
    logic          prev_rst;
    prev_req  = 1'b0;
    prev_addr = '0;
    prev_rst  = 1'b0;
    forever begin
      @(posedge tb_clk);
      #1;
      if (rst_n && prev_rst) begin
        chk("set_onehot0", 32'($onehot0(set)), 32'd1);
        chk("set_only_after_ack", 32'(set != '0), 32'(mem_ack && prev_req));
        if (prev_req && !mem_ack) begin
          chk("req_hold", 32'(mem_req), 32'd1);
          chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
        end
        if (set != '0) chk("set_while_busy", 32'(busy), 32'd1);
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      prev_rst  = rst_n;
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req"},  32'(mem_req),  32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_set"},  32'(set),      32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy),     32'd0);
    chk({tag, "_done"}, 32'(done),     32'd0);
  endtask

  task automatic check_bank(input string tag, input logic [AW-1:0] base);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_wreg%0d", tag, i), 32'(wreg[i]), 32'(exp_word(base + AW'(i))));
  endtask

  // One load from base; returns early after stop_after writes if below NR
  task automatic run_load(input logic [AW-1:0] base, input int stop_after,
                          input bit poke, input bit timed);
    int cyc;
    int got;
    bit done_seen;
    got       = 0;
    done_seen = 1'b0;
    @(negedge tb_clk);
    base_addr = base;
    start     = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("req_after_start", 32'(mem_req), 32'd1);
    chk("addr_after_start", 32'(mem_addr), 32'(base));
    while (cyc < 300) begin
      if (start) start = 1'b0;
      if (set != '0) begin
        chk("set_walk", 32'(set), 32'd1 << got);
        chk("write_data", 32'(out_data), 32'(exp_word(base + AW'(got))));
        got++;
        if (poke && got == 4) start = 1'b1;
        if (got == stop_after && stop_after < NR) break;
      end
      if (done) begin
        done_seen = 1'b1;
        chk("writes_before_done", 32'(got), 32'(NR));
        if (timed) chk("done_latency", 32'(cyc), 32'(3 * NR + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      @(negedge tb_clk);
      cyc++;
    end
    start = 1'b0;
    if (stop_after >= NR) begin
      chk("done_seen", 32'(done_seen), 32'd1);
      if (done_seen) begin
        @(negedge tb_clk);
        chk("done_single_pulse", 32'(done), 32'd0);
      end
    end else begin
      chk("partial_writes", 32'(got), 32'(stop_after));
    end
  endtask

  // Directed sequence
  initial begin
    int w;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    repeat (2) @(negedge tb_clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge tb_clk);
    check_outputs_zero("idle");

    // Test 1: async reset while in REQ for the third word
    run_load(10'h010, 2, 1'b0, 1'b0);
    w = 0;
    while (!mem_req && w < 20) begin
      @(negedge tb_clk);
      w++;
    end
    chk("t1_in_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("t1_async");
    @(negedge tb_clk);
    @(negedge tb_clk);
    check_outputs_zero("t1_held");
    chk("t1_wreg0", 32'(wreg[0]), 32'(exp_word(10'h010)));
    chk("t1_wreg1", 32'(wreg[1]), 32'(exp_word(10'h011)));
    chk("t1_wreg2", 32'(wreg[2]), 32'h00);
    rst_n = 1'b1;
    @(negedge tb_clk);

    // Test 2: zero-wait full load from 0x010
    max_delay = 0;
    run_load(10'h010, NR, 1'b0, 1'b1);
    check_bank("t2", 10'h010);

    // Test 4: Start pulsed while busy, then Ack in IDLE
    run_load(10'h040, NR, 1'b1, 1'b1);
    check_bank("t4", 10'h040);
    @(posedge tb_clk);
    #2 inject_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge tb_clk);
      chk("t4_idle_set", 32'(set), 32'd0);
      chk("t4_idle_busy", 32'(busy), 32'd0);
      chk("t4_idle_done", 32'(done), 32'd0);
      chk("t4_idle_req", 32'(mem_req), 32'd0);
      chk("t4_data_held", 32'(out_data), 32'(exp_word(10'h048)));
    end

    // Test 5: address wrap from 0x3FE
    run_load(10'h3FE, NR, 1'b0, 1'b1);
    check_bank("t5", 10'h3FE);

    // Test 3: random Ack delay 0..5
    max_delay = 5;
    run_load(10'h010, NR, 1'b0, 1'b0);
    check_bank("t3", 10'h010);
    max_delay = 0;

    // Test 6: reset after four writes, then a full reload from 0x020
    run_load(10'h100, 4, 1'b0, 1'b0);
    @(posedge tb_clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    @(negedge tb_clk);
    @(negedge tb_clk);
    chk("t6_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_partial_wreg%0d", i), 32'(wreg[i]), 32'(exp_word(10'h100 + AW'(i))));
    chk("t6_untouched_wreg4", 32'(wreg[4]), 32'(exp_word(10'h014)));
    run_load(10'h020, NR, 1'b0, 1'b1);
    check_bank("t6", 10'h020);

    repeat (3) @(negedge tb_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
